// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Handshaked, byte-addressed, big-endian data memory for the load/store
//   stage. Byte/halfword/word access, sign or zero extension on loads,
//   WAIT_CYCLES extra wait states per access, error reporting for illegal
//   size and out-of-range addresses.
//
//   Optional feature: define DATAMEM_ALIGN_CHECK_EN to report misaligned
//   halfword/word accesses as errors. When undefined, the low address bits
//   are forced to natural alignment instead.
//
// Parameters
//   ADDR_WIDTH   byte-address bits implemented (capacity 2**ADDR_WIDTH bytes)
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   req       in   access request (sampled only while ready)
//   we        in   1 = store, 0 = load
//   size      in   00 byte, 01 half, 10 word, 11 illegal
//   sign_ext  in   loads: 1 sign-extend, 0 zero-extend
//   addr      in   byte address (MSB of the item)
//   wdata     in   store data, right-aligned
//   ready     out  idle; request accepted this cycle if req=1
//   done      out  one-cycle completion pulse
//   err       out  access rejected (valid with done, held until next RESP)
//   rdata     out  load data (valid with done, held until next RESP)
//
// state | meaning
// IDLE  | waiting for req, ready=1
// BUSY  | wait counter running; access performed when it reaches zero
// RESP  | done=1 for one cycle, err/rdata valid
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        q_we;
  logic [1:0]  q_size;
  logic        q_sign;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;

  logic [7:0]  mem [DEPTH];

  logic                  access;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [7:0]            b0, b1, b2, b3;
  logic [31:0]           ld_data;

  assign access = (state == BUSY) && (wait_cnt == 4'd0);

  // Base byte index with the low bits forced to natural alignment. With the
  // alignment check enabled a misaligned access is an error, so the forced
  // bits never reach the array in that build either. Because the base is
  // aligned, OR-ing in the byte offset never carries and the item cannot
  // straddle the top of the array.
  always_comb begin
    a0 = q_addr[ADDR_WIDTH-1:0];
    if (q_size == 2'b01)
      a0[0] = 1'b0;
    else if (q_size == 2'b10)
      a0[1:0] = 2'b00;
  end

  assign a1 = {a0[ADDR_WIDTH-1:1], 1'b1};
  assign a2 = {a0[ADDR_WIDTH-1:2], 2'b10};
  assign a3 = {a0[ADDR_WIDTH-1:2], 2'b11};

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

`ifdef DATAMEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((q_size == 2'b01) && q_addr[0]) ||
                    ((q_size == 2'b10) && (q_addr[1:0] != 2'b00));
  assign acc_err  = (q_size == 2'b11) || (q_addr[31:ADDR_WIDTH] != '0) || misalign;
`else
  assign acc_err  = (q_size == 2'b11) || (q_addr[31:ADDR_WIDTH] != '0);
`endif

  // Big-endian: the lowest address holds the most significant byte.
  always_comb begin
    ld_data = 32'd0;
    case (q_size)
      2'b00:   ld_data = {{24{q_sign & b0[7]}}, b0};
      2'b01:   ld_data = {{16{q_sign & b0[7]}}, b0, b1};
      2'b10:   ld_data = {b0, b1, b2, b3};
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
      q_we     <= 1'b0;
      q_size   <= 2'b00;
      q_sign   <= 1'b0;
      q_addr   <= 32'd0;
      q_wdata  <= 32'd0;
      err      <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      if ((state == IDLE) && req) begin
        wait_cnt <= 4'(WAIT_CYCLES);
        q_we     <= we;
        q_size   <= size;
        q_sign   <= sign_ext;
        q_addr   <= addr;
        q_wdata  <= wdata;
      end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (access) begin
        err   <= acc_err;
        // Stores and rejected loads return zero.
        rdata <= (q_we || acc_err) ? 32'd0 : ld_data;
      end
    end
  end

  // Array is not reset. A reset during BUSY returns the FSM to IDLE, so the
  // pending access edge never occurs and nothing is written.
  always_ff @(posedge clk) begin
    if (access && q_we && !acc_err) begin
      case (q_size)
        2'b00: mem[a0] <= q_wdata[7:0];
        2'b01: begin
          mem[a0] <= q_wdata[15:8];
          mem[a1] <= q_wdata[7:0];
        end
        2'b10: begin
          mem[a0] <= q_wdata[31:24];
          mem[a1] <= q_wdata[23:16];
          mem[a2] <= q_wdata[15:8];
          mem[a3] <= q_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: scoreboard queue filled by the driver from a
// byte-array reference model, drained by an independent monitor on done.
// Model follows DATAMEM_ALIGN_CHECK_EN the same way the build does.
module tb_data_mem_ctrl;

  localparam int AW  = 10;
  localparam int W   = 3;
  localparam int CAP = 1 << AW;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         busy_until = 0;
  bit         chk_rdy = 1'b0;
  logic [7:0] mmem [CAP];

  data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: item of n bytes at address a, big-endian, no wrap.
  function automatic void model(input logic w, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd);
    int     n;
    longint ea;
    longint v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ea = 64'(a);
`ifdef DATAMEM_ALIGN_CHECK_EN
    e = (ea % n) != 0;
`else
    e = 1'b0;
    ea = ea - (ea % n);
`endif
    e  = e || (sz == 2'd3) || (ea + n > CAP);
    rd = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++)
          mmem[int'(ea) + i] = 8'(wd >> (8 * (n - 1 - i)));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++)
          v = v * 256 + longint'(mmem[int'(ea) + i]);
        if (sx && v >= (64'sd1 << (8 * n - 1)))
          v = v - (64'sd1 << (8 * n));
        rd = 32'(v);
      end
    end
  endfunction

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold);
    logic        e;
    logic [31:0] r;
    exp_t        x;
    int          g;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    g = 0;
    while (!ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: ready=%0b after %0d cycles, required 1", ready, g);
      req = 1'b0;
      return;
    end
    model(w, sz, sx, a, wd, e, r);
    x.err = e; x.rdata = r; x.cyc = cyc + W + 2;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    busy_until = cyc + W + 2;
    if (hold) begin
      // Keep requesting with junk; DUT must ignore it until ready again.
      addr = $urandom; wdata = $urandom; we = 1'($urandom);
      size = 2'($urandom); sign_ext = 1'($urandom);
    end else begin
      req = 1'b0;
    end
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (chk_rdy) begin
          total++;
          if (ready !== (cyc >= busy_until)) begin
            bad++;
            $display("FAIL ready_timing: cyc=%0d ready=%0b required %0b", cyc, ready, cyc >= busy_until);
          end
        end
        if (done) begin
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: cyc=%0d err=%0b rdata=%h, none pending", cyc, err, rdata);
          end else begin
            x = sbq.pop_front();
            if (err !== x.err || rdata !== x.rdata || cyc != x.cyc) begin
              bad++;
              $display("FAIL response: cyc=%0d err=%0b rdata=%h, required cyc=%0d err=%0b rdata=%h",
                       cyc, err, rdata, x.cyc, x.err, x.rdata);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  initial begin
    int g;
    int r;
    logic [31:0] a;
    logic [1:0]  sz;

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_err",   32'(err),   32'd0);
    chk("reset_rdata", rdata,      32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_rdy = 1'b1;

    // Initialise every byte, back-to-back with req held during busy.
    for (int i = 0; i < CAP; i += 4)
      issue(1'b1, 2'd2, 1'b0, 32'(i), $urandom, 1'b1);

    issue(1'b1, 2'd2, 1'b0, 32'h8,   32'h11223344, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h8,   32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h9,   32'h0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h10,  32'h80, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h10,  32'h0, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h12,  32'hBEEF, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h12,  32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h12,  32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 32'h20,  32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h21,  32'hAABBCCDD, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h20,  32'h0, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h3FF, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(CAP - $urandom_range(0, 4));
      else             a = 32'($urandom_range(0, CAP - 1));
      r  = $urandom_range(0, 7);
      sz = (r == 7) ? 2'd3 : 2'(r % 3);
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, (i != 299) && ($urandom_range(0, 1) == 1));
      if (!req) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    g = 0;
    while (sbq.size() > 0 && g < 500) begin
      @(negedge clk);
      g++;
    end

    // Reset in BUSY of a store: abandoned, nothing written.
    chk_rdy = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h40; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("busy_reset_ready", 32'(ready), 32'd1);
    chk("busy_reset_done",  32'(done),  32'd0);
    chk("busy_reset_rdata", rdata,      32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    busy_until = 0;
    chk_rdy = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, 1'b0);

    g = 0;
    while (sbq.size() > 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
